// File: rtl/brl_normalize.sv
// brl_normalize: iterative leading-one normalizer, one nibble per clock.
// Finds the leading one of a 32-bit operand, reports the signed shift count
// (msb - NORM_POS) and the operand shifted so its leading one sits at NORM_POS.
// Optional build macro NORM_EARLY_EXIT_EN: leave SCAN on the first nonzero
// nibble instead of always scanning all eight. Results are identical either way.
module brl_normalize #(
    parameter int NORM_POS = 22
) (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        start,
    input  logic [31:0] srcd,
    output logic        busy,
    output logic        done,
    output logic [31:0] normq,
    output logic [31:0] mantq,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q;
    logic               hit_q;
    logic [4:0]         msb_q;
    logic [31:0]        op_q;

    logic [31:0]        op_sh;
    logic [3:0]         nib;
    logic               nib_nz;
    logic               first_hit;
    logic               scan_exit;
    logic               accept;
    logic signed [5:0]  diff;
    logic signed [5:0]  neg_diff;
    logic [31:0]        norm_d;
    logic [31:0]        mant_d;

    // Position of the highest set bit inside a nibble (0 when the nibble is zero).
    function automatic logic [1:0] nib_lead(input logic [3:0] n);
        if (n[3])      return 2'd3;
        else if (n[2]) return 2'd2;
        else if (n[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    assign busy      = (state_q != IDLE);
    assign accept    = start && (state_q == IDLE);
    assign op_sh     = op_q >> {idx_q, 2'b00};
    assign nib       = op_sh[3:0];
    assign nib_nz    = |nib;
    assign first_hit = (state_q == SCAN) && nib_nz && !hit_q;

`ifdef NORM_EARLY_EXIT_EN
    assign scan_exit = nib_nz || (idx_q == 3'd0);
`else
    assign scan_exit = (idx_q == 3'd0);
`endif

    // Next-state logic for the IDLE -> SCAN -> SHIFT -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (scan_exit) state_d = SHIFT;
            SHIFT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result formation in SHIFT: signed count and direction-dependent shift.
    always_comb begin
        diff     = $signed({1'b0, msb_q}) - $signed(6'(NORM_POS));
        neg_diff = -diff;
        norm_d   = '0;
        mant_d   = '0;
        if (hit_q) begin
            norm_d = {{26{diff[5]}}, diff};
            if (diff > 6'sd0) mant_d = op_q >> diff[4:0];
            else              mant_d = op_q << neg_diff[4:0];
        end
    end

    // Control state, scan bookkeeping and registered outputs.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            idx_q   <= 3'd7;
            hit_q   <= 1'b0;
            done    <= 1'b0;
            normq   <= '0;
            mantq   <= '0;
            zero    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q <= 3'd7;
                        hit_q <= 1'b0;
                    end
                end
                SCAN: begin
                    idx_q <= idx_q - 3'd1;
                    if (first_hit) hit_q <= 1'b1;
                end
                SHIFT: begin
                    done  <= 1'b1;
                    normq <= norm_d;
                    mantq <= mant_d;
                    zero  <= !hit_q;
                end
                default: ;
            endcase
        end
    end

    // Operand capture and leading-one position; masked by hit_q when unused.
    always_ff @(posedge sys_clk) begin
        if (accept)    op_q  <= srcd;
        if (first_hit) msb_q <= {idx_q, nib_lead(nib)};
    end

endmodule

// File: tb/tb_brl_normalize.sv
// tb_brl_normalize: directed and randomized checks of brl_normalize against a
// behavioural reference (leading-one search plus a per-operation countdown).
module tb_brl_normalize;

    localparam int NORM_POS = 22;

    logic        sys_clk = 1'b0;
    logic        resetl  = 1'b1;
    logic        start   = 1'b0;
    logic [31:0] srcd    = '0;
    logic        busy;
    logic        done;
    logic [31:0] normq;
    logic [31:0] mantq;
    logic        zero;

    int n_total = 0;
    int n_pass  = 0;

    brl_normalize #(.NORM_POS(NORM_POS)) dut (
        .sys_clk(sys_clk),
        .resetl (resetl),
        .start  (start),
        .srcd   (srcd),
        .busy   (busy),
        .done   (done),
        .normq  (normq),
        .mantq  (mantq),
        .zero   (zero)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference: leading-one search by plain loop, shift by arithmetic.
    function automatic void ref_norm(input logic [31:0] d, output logic [31:0] n,
                                     output logic [31:0] m, output logic z, output int lat);
        int msb = -1;
        int sh;
        for (int i = 31; i >= 0; i--)
            if (d[i] && msb < 0) msb = i;
        if (msb < 0) begin
            n = '0; m = '0; z = 1'b1; lat = 9;
        end else begin
            sh = msb - NORM_POS;
            n  = 32'(sh);
            m  = (sh > 0) ? (d >> sh) : (d << (-sh));
            z  = 1'b0;
`ifdef NORM_EARLY_EXIT_EN
            lat = 9 - msb / 4;
`else
            lat = 9;
`endif
        end
    endfunction

    function automatic int lat_of(input logic [31:0] d);
        logic [31:0] n, m;
        logic z;
        int l;
        ref_norm(d, n, m, z, l);
        return l;
    endfunction

    // Model state: busy countdown and the result that will appear on done.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_norm = '0, m_mant = '0, p_norm = '0, p_mant = '0;
    logic        m_zero = 1'b0, p_zero = 1'b0;

    always @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
            m_norm = '0; m_mant = '0; m_zero = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_norm = p_norm; m_mant = p_mant; m_zero = p_zero;
                end
            end else if (start) begin
                ref_norm(srcd, p_norm, p_mant, p_zero, m_cnt);
                m_busy = 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge sys_clk) begin
        chk("cyc_busy",  32'(busy),  32'(m_busy));
        chk("cyc_done",  32'(done),  32'(m_done));
        chk("cyc_normq", normq,      m_norm);
        chk("cyc_mantq", mantq,      m_mant);
        chk("cyc_zero",  32'(zero),  32'(m_zero));
    end

    // Single operation with literal expectations and latency from accept edge.
    task automatic run_op(input string name, input logic [31:0] d, input logic [31:0] en,
                          input logic [31:0] em, input logic ez, input int elat);
        int  cyc;
        bit  seen;
        @(posedge sys_clk); #2;
        start = 1'b1; srcd = d;
        @(posedge sys_clk); #2;
        start = 1'b0; srcd = $urandom;
        cyc = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(posedge sys_clk); #1;
            cyc++;
            if (done) seen = 1;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(cyc), 32'(elat));
        chk({name, "_normq"}, normq, en);
        chk({name, "_mantq"}, mantq, em);
        chk({name, "_zero"}, 32'(zero), 32'(ez));
    endtask

    initial begin
        logic [31:0] pn, pm;
        logic pz;
        int pl, cyc, ndone;
        bit seen;

        #1 resetl = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_normq", normq, 32'd0);
        chk("rst_mantq", mantq, 32'd0);
        chk("rst_zero",  32'(zero), 32'd0);
        #1 resetl = 1'b1;

        // Pin the reference model itself with hand-computed values.
        ref_norm(32'h0000_0100, pn, pm, pz, pl);
        chk("model_norm_100", pn, 32'hFFFF_FFF2);
        chk("model_mant_100", pm, 32'h0040_0000);
        ref_norm(32'h1234_5678, pn, pm, pz, pl);
        chk("model_mant_12345678", pm, 32'h0048_D159);

`ifdef NORM_EARLY_EXIT_EN
        run_op("msb31", 32'h8000_0000, 32'h0000_0009, 32'h0040_0000, 1'b0, 2);
`else
        run_op("msb31", 32'h8000_0000, 32'h0000_0009, 32'h0040_0000, 1'b0, 9);
`endif
        run_op("msb0",  32'h0000_0001, 32'hFFFF_FFEA, 32'h0040_0000, 1'b0, 9);
        run_op("zero",  32'h0000_0000, 32'h0, 32'h0, 1'b1, 9);
        run_op("msb22", 32'h0040_0000, 32'h0, 32'h0040_0000, 1'b0, lat_of(32'h0040_0000));

        // Start pulsed while busy must be ignored.
        @(posedge sys_clk); #2;
        start = 1'b1; srcd = 32'h00C0_0000;
        @(posedge sys_clk); #2;
        start = 1'b0; srcd = '0;
        @(posedge sys_clk); #2;
        start = 1'b1; srcd = 32'h0000_0001;
        @(posedge sys_clk); #2;
        start = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(posedge sys_clk); #1;
            if (done) ndone++;
        end
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_normq", normq, 32'h0000_0001);
        chk("ign_mantq", mantq, 32'h0060_0000);

        // Asynchronous reset mid-scan discards the operation.
        @(posedge sys_clk); #2;
        start = 1'b1; srcd = 32'h0000_0100;
        @(posedge sys_clk); #2;
        start = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2 resetl = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_normq", normq, 32'd0);
        chk("mid_rst_mantq", mantq, 32'd0);
        @(posedge sys_clk); #2 resetl = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge sys_clk); #1;
            if (done) ndone++;
        end
        chk("mid_rst_no_done", 32'(ndone), 32'd0);
        run_op("after_rst", 32'h0000_0100, 32'hFFFF_FFF2, 32'h0040_0000, 1'b0,
               lat_of(32'h0000_0100));

        // Back-to-back: start held high through the done cycle of the prior op.
        @(posedge sys_clk); #2;
        start = 1'b1; srcd = 32'h8000_0000;
        @(posedge sys_clk); #2;
        srcd = 32'h1234_5678;
        cyc = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(posedge sys_clk); #1;
            cyc++;
            if (done) seen = 1;
        end
        chk("b2b_first_done", 32'(seen), 32'd1);
        @(posedge sys_clk); #2;
        start = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(posedge sys_clk); #1;
            cyc++;
            if (done) seen = 1;
        end
        chk("b2b_second_done", 32'(seen), 32'd1);
        chk("b2b_latency", 32'(cyc), 32'(lat_of(32'h1234_5678)));
        chk("b2b_normq", normq, 32'h0000_0006);
        chk("b2b_mantq", mantq, 32'h0048_D159);

        // Randomized traffic: random operands with varied leading-one position,
        // random start activity including pulses while busy.
        repeat (1500) begin
            @(posedge sys_clk); #2;
            start = ($urandom_range(0, 2) == 0);
            srcd  = $urandom >> $urandom_range(0, 32);
        end
        #2 start = 1'b0;
        repeat (15) @(posedge sys_clk);
        @(negedge sys_clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
